// File: rtl/rtc_bram.sv
// rtc_bram: battery-backed parameter RAM and real-time clock behind the
// DATA ($C033) and CONTROL ($C034) soft switches.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high; leaves BRAM, wp and seconds untouched
//   cen    - CPU-rate enable; advances the seconds prescaler and busy counter
//   addr   - 0 = DATA, 1 = CONTROL
//   rw     - 1 = read, 0 = write
//   din    - write data
//   strobe - one-clk access pulse, honoured regardless of cen
//   dout   - read data, combinational so it is valid during the strobe cycle
module rtc_bram #(
   parameter int unsigned TICKS_PER_SEC = 2500000,
   parameter int unsigned BUSY_TICKS    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cen,
   input  logic       addr,
   input  logic       rw,
   input  logic [7:0] din,
   input  logic       strobe,
   output logic [7:0] dout
);

   localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int unsigned BW = $clog2(BUSY_TICKS + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [BW-1:0] BUSY_LOAD  = BW'(BUSY_TICKS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXT  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    data_q, data_d;
   logic [1:0]    ctl_q;
   logic [BW-1:0] busy_cnt_q;
   // Bit 7 of the command byte is a don't-care, so only 6:0 is kept.
   logic [6:0]    cmd_q, cmd_d;
   logic [2:0]    ext_q, ext_d;
   logic [7:0]    ptr_q, ptr_d;
   logic [PW-1:0] presc_q;

   // Battery domain: power-up contents, never touched by reset.
   logic [31:0]   secs_q = 32'h0000_0000;
   logic          wp_q   = 1'b0;
   logic [7:0]    bram [256] = '{default: 8'h00};

   logic       busy;
   logic       wr_ok, wr_data, wr_ctl, xfer;
   logic       sec_tick;
   logic       tgt_sec, tgt_wp, tgt_bram;
   logic [7:0] sec_byte, tgt_rdata;
   logic       bram_we, sec_we, wp_we;

   // Access decode; anything arriving while busy is ignored.
   assign busy     = (busy_cnt_q != '0);
   assign wr_ok    = strobe && !rw && !busy && !reset;
   assign wr_data  = wr_ok && !addr;
   assign wr_ctl   = wr_ok && addr;
   assign xfer     = wr_ctl && din[7];
   assign sec_tick = cen && (presc_q == PRESC_LAST) && !reset;

   // Reads see only current register state, never this edge's updates.
   assign dout = addr ? {busy, ctl_q, 5'b0_0000} : data_q;

   // Target decode of the latched command.
   assign tgt_sec  = (cmd_q[6:4] == 3'b000) && (cmd_q[1:0] == 2'b01);
   assign tgt_wp   = (cmd_q == 7'h35);
   assign tgt_bram = (cmd_q[6:3] == 4'b0111);

   // Seconds byte select, little-endian.
   always_comb begin
      sec_byte = secs_q[7:0];
      case (cmd_q[3:2])
         2'd0:    sec_byte = secs_q[7:0];
         2'd1:    sec_byte = secs_q[15:8];
         2'd2:    sec_byte = secs_q[23:16];
         default: sec_byte = secs_q[31:24];
      endcase
   end

   // Read value of the current target; unmapped targets read zero.
   always_comb begin
      tgt_rdata = 8'h00;
      if (tgt_sec)       tgt_rdata = sec_byte;
      else if (tgt_wp)   tgt_rdata = {wp_q, 7'b000_0000};
      else if (tgt_bram) tgt_rdata = bram[ptr_q];
   end

   // Transfer FSM: next state, command capture and target write enables.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cmd_d   = cmd_q;
      ext_d   = ext_q;
      ptr_d   = ptr_q;
      bram_we = 1'b0;
      sec_we  = 1'b0;
      wp_we   = 1'b0;

      if (wr_data) data_d = din;

      if (xfer) begin
         case (state_q)
            S_IDLE: begin
               cmd_d = data_q[6:0];
               if (data_q[6:3] == 4'b0111) begin
                  ext_d   = data_q[2:0];
                  state_d = S_EXT;
               end else begin
                  state_d = S_DATA;
               end
            end
            S_EXT: begin
               ptr_d   = {ext_q, data_q[6:2]};
               state_d = S_DATA;
            end
            S_DATA: begin
               if (din[6]) begin
                  data_d = tgt_rdata;
               end else begin
                  bram_we = tgt_bram && !wp_q;
                  sec_we  = tgt_sec && !wp_q;
                  wp_we   = tgt_wp;
               end
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
         // LAST closes the transaction after this step's action.
         if (din[5]) state_d = S_IDLE;
      end
   end

   // Resettable state: FSM, DATA/CTL, busy counter, prescaler.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         data_q     <= 8'h00;
         ctl_q      <= 2'b00;
         busy_cnt_q <= '0;
         cmd_q      <= 7'h00;
         ext_q      <= 3'b000;
         ptr_q      <= 8'h00;
         presc_q    <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cmd_q   <= cmd_d;
         ext_q   <= ext_d;
         ptr_q   <= ptr_d;
         if (wr_ctl) ctl_q <= din[6:5];
         if (xfer)
            busy_cnt_q <= BUSY_LOAD;
         else if (cen && busy)
            busy_cnt_q <= busy_cnt_q - BW'(1);
         if (cen) presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      end
   end

   // Battery domain; a seconds-byte write swallows a coincident increment.
   always_ff @(posedge clk) begin
      if (bram_we) bram[ptr_q] <= data_q;
      if (wp_we)   wp_q        <= data_q[7];
      if (sec_we) begin
         case (cmd_q[3:2])
            2'd0:    secs_q[7:0]   <= data_q;
            2'd1:    secs_q[15:8]  <= data_q;
            2'd2:    secs_q[23:16] <= data_q;
            default: secs_q[31:24] <= data_q;
         endcase
      end else if (sec_tick) begin
         secs_q <= secs_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_rtc_bram.sv
// tb_rtc_bram: directed plus randomized checks of rtc_bram against a
// transaction-level model (BRAM array, seconds arithmetic, busy timer).
module tb_rtc_bram;

   localparam int unsigned TPS = 4;
   localparam int unsigned BT  = 8;

   logic       clk = 1'b0;
   logic       reset, cen, addr, rw, strobe;
   logic [7:0] din, dout;

   int total = 0;
   int bad   = 0;

   rtc_bram #(.TICKS_PER_SEC(TPS), .BUSY_TICKS(BT)) dut (
      .clk(clk), .reset(reset), .cen(cen), .addr(addr), .rw(rw),
      .din(din), .strobe(strobe), .dout(dout)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [7:0]  m_data;
   logic [1:0]  m_ctl;
   int unsigned m_busy_left;
   logic [31:0] m_secs;
   int unsigned m_presc;
   logic        m_wp;
   logic [7:0]  m_bram [256];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   // One cen tick of model time; sec_written suppresses the increment.
   task automatic model_cen(input bit sec_written);
      if (m_busy_left != 0) m_busy_left--;
      if (m_presc == TPS - 1) begin
         m_presc = 0;
         if (!sec_written) m_secs = m_secs + 32'd1;
      end else begin
         m_presc++;
      end
   endtask

   function automatic logic [7:0] sec_byte(input int idx);
      return 8'(m_secs >> (8 * idx));
   endfunction

   task automatic strobe_wr(input logic a, input logic [7:0] d, input bit c, input bit secw);
      bit taken;
      taken = (m_busy_left == 0);
      addr = a; rw = 1'b0; din = d; strobe = 1'b1; cen = c;
      @(posedge clk);
      #1;
      strobe = 1'b0; cen = 1'b0; rw = 1'b1;
      if (c) model_cen(secw);
      if (taken) begin
         if (!a) m_data = d;
         else begin
            m_ctl = d[6:5];
            if (d[7]) m_busy_left = BT;
         end
      end
   endtask

   task automatic strobe_rd(input logic a, output logic [7:0] obs);
      addr = a; rw = 1'b1; strobe = 1'b1; cen = 1'b0;
      #2;
      obs = dout;
      @(posedge clk);
      #1;
      strobe = 1'b0;
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         cen = 1'b1;
         @(posedge clk);
         #1;
         cen = 1'b0;
         model_cen(1'b0);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_data = 8'h00; m_ctl = 2'b00; m_busy_left = 0; m_presc = 0;
   endtask

   task automatic set_data(input logic [7:0] d);
      strobe_wr(1'b0, d, 1'b0, 1'b0);
   endtask

   // CONTROL start followed by enough cen ticks for busy to expire.
   task automatic start(input logic [7:0] c);
      strobe_wr(1'b1, c, 1'b0, 1'b0);
      tick(BT);
   endtask

   task automatic cmd_rd(input logic [7:0] c, output logic [7:0] obs);
      logic [7:0] e;
      set_data(c);
      start(8'h80);
      if (c[6:4] == 3'b000 && c[1:0] == 2'b01) e = sec_byte(int'(c[3:2]));
      else if (c[6:0] == 7'h35)                e = {m_wp, 7'b0};
      else                                     e = 8'h00;
      start(8'hC0);
      m_data = e;
      strobe_rd(1'b0, obs);
   endtask

   task automatic cmd_wr(input logic [7:0] c, input logic [7:0] v);
      set_data(c);
      start(8'h80);
      set_data(v);
      if (c[6:4] == 3'b000 && c[1:0] == 2'b01 && !m_wp)
         m_secs[8*int'(c[3:2]) +: 8] = v;
      else if (c[6:0] == 7'h35)
         m_wp = v[7];
      start(8'h80);
   endtask

   task automatic bram_wr(input logic [7:0] a, input logic [7:0] v);
      set_data({1'b0, 4'b0111, a[7:5]});
      start(8'h80);
      set_data({1'b0, a[4:0], 2'b00});
      start(8'h80);
      set_data(v);
      if (!m_wp) m_bram[a] = v;
      start(8'hA0);
   endtask

   task automatic bram_rd(input logic [7:0] a, output logic [7:0] obs);
      set_data({1'b1, 4'b0111, a[7:5]});
      start(8'h80);
      set_data({1'b0, a[4:0], 2'b00});
      start(8'h80);
      start(8'hE0);
      m_data = m_bram[a];
      strobe_rd(1'b0, obs);
   endtask

   initial begin
      logic [7:0] obs, v;
      logic [7:0] ra [6];
      logic       b;
      int         idx;

      reset = 1'b1; cen = 1'b0; addr = 1'b0; rw = 1'b1; din = 8'h00; strobe = 1'b0;
      m_secs = 32'h0; m_wp = 1'b0; m_busy_left = 0; m_presc = 0; m_data = 8'h00; m_ctl = 2'b00;
      for (int i = 0; i < 256; i++) m_bram[i] = 8'h00;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state and plain CONTROL writes
      strobe_rd(1'b1, obs); chk("reset_ctl", obs, 8'h00);
      strobe_rd(1'b0, obs); chk("reset_data", obs, 8'h00);
      strobe_wr(1'b1, 8'h60, 1'b0, 1'b0);
      strobe_rd(1'b1, obs); chk("ctl_bits_60", obs, 8'h60);
      strobe_wr(1'b1, 8'h1F, 1'b0, 1'b0);
      strobe_rd(1'b1, obs); chk("ctl_1f", obs, 8'h00);

      // Seconds after exactly 12 cen ticks from power-up
      set_data(8'h01);
      strobe_wr(1'b1, 8'h80, 1'b0, 1'b0);
      tick(12);
      v = sec_byte(0);
      strobe_wr(1'b1, 8'hC0, 1'b0, 1'b0);
      m_data = v;
      tick(BT);
      strobe_rd(1'b0, obs);
      chk("sec_12_ticks", obs, 8'h03);
      chk("sec_12_model", obs, m_data);

      // Seconds byte1 write/read
      cmd_wr(8'h05, 8'h12);
      cmd_rd(8'h05, obs); chk("sec_b1_rd", obs, 8'h12);

      // BRAM 0xAB write then read
      bram_wr(8'hAB, 8'h5A);
      bram_rd(8'hAB, obs); chk("bram_ab", obs, 8'h5A);

      // Randomized BRAM traffic
      for (int i = 0; i < 6; i++) begin
         ra[i] = 8'($urandom_range(0, 255));
         if (ra[i] == 8'hAB) ra[i] = 8'h54;
         bram_wr(ra[i], 8'($urandom_range(0, 255)));
      end
      for (int i = 5; i >= 0; i--) begin
         bram_rd(ra[i], obs); chk($sformatf("bram_rand%0d", i), obs, m_data);
      end
      bram_rd(ra[0] ^ 8'h01, obs); chk("bram_neighbor", obs, m_data);

      // Randomized seconds byte write, then all four bytes
      idx = $urandom_range(1, 3);
      cmd_wr({4'b0000, 2'(idx), 2'b01}, 8'($urandom_range(0, 255)));
      for (int i = 0; i < 4; i++) begin
         cmd_rd({4'b0000, 2'(i), 2'b01}, obs); chk($sformatf("sec_byte%0d", i), obs, m_data);
      end

      // Unmapped target reads zero
      cmd_rd(8'h02, obs); chk("unmapped", obs, 8'h00);

      // Seconds write landing on an increment edge wins
      v = 8'($urandom_range(0, 200));
      set_data(8'h01);
      start(8'h80);
      set_data(v);
      for (int k = 0; k < int'(TPS) && m_presc != TPS - 1; k++) tick(1);
      m_secs[7:0] = v;
      strobe_wr(1'b1, 8'h80, 1'b1, 1'b1);
      tick(BT);
      cmd_rd(8'h01, obs);
      chk("sec_wr_vs_tick_model", obs, m_data);
      chk("sec_wr_vs_tick", obs, v + 8'd4);

      // Busy lasts exactly BT cen ticks; accesses meanwhile are ignored
      set_data(8'h77);
      strobe_wr(1'b1, 8'hA0, 1'b0, 1'b0);
      for (int i = 0; i <= int'(BT); i++) begin
         strobe_rd(1'b1, obs);
         b = (i < int'(BT));
         chk($sformatf("busy_t%0d", i), obs, {b, 2'b01, 5'b0});
         if (i == 2) strobe_wr(1'b0, 8'hFF, 1'b0, 1'b0);
         if (i == 3) strobe_wr(1'b1, 8'hC0, 1'b0, 1'b0);
         if (i < int'(BT)) tick(1);
      end
      strobe_rd(1'b0, obs); chk("busy_data_kept", obs, 8'h77);
      bram_rd(8'hAB, obs); chk("busy_no_launch", obs, 8'h5A);

      // Strobe on the busy-clearing edge is still ignored
      set_data(8'h11);
      strobe_wr(1'b1, 8'hA0, 1'b0, 1'b0);
      tick(BT - 1);
      strobe_wr(1'b0, 8'hEE, 1'b1, 1'b0);
      strobe_rd(1'b0, obs); chk("clear_edge_data", obs, 8'h11);
      strobe_rd(1'b1, obs); chk("clear_edge_ctl", obs, 8'h20);

      // Write protect
      cmd_wr(8'h35, 8'h80);
      bram_wr(8'hAB, 8'h00);
      bram_rd(8'hAB, obs); chk("wp_bram", obs, 8'h5A);
      cmd_rd(8'h35, obs); chk("wp_reg", obs, 8'h80);
      cmd_wr(8'h09, 8'h55);
      cmd_rd(8'h09, obs); chk("wp_sec", obs, m_data);
      cmd_wr(8'h35, 8'h00);
      cmd_rd(8'h35, obs); chk("wp_clear", obs, 8'h00);

      // Reset in the middle of a BRAM transaction
      set_data(8'h3D);
      start(8'h80);
      set_data(8'h2C);
      strobe_wr(1'b1, 8'h80, 1'b0, 1'b0);
      do_reset();
      strobe_rd(1'b1, obs); chk("midrst_ctl", obs, 8'h00);
      strobe_rd(1'b0, obs); chk("midrst_data", obs, 8'h00);
      cmd_rd(8'h01, obs); chk("midrst_newcmd", obs, m_data);
      bram_rd(8'hAB, obs); chk("midrst_bram", obs, 8'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
